mem_stage_sram_ctrl: RTL and testbench

//   Memory stage of the ARM pipeline, directly downstream of the execute stage. Consumes execute

---
 rtl/mem_stage_sram_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_stage_sram_ctrl
//  Purpose  : Memory stage of the ARM pipeline. Performs 32-bit loads/stores
//             against an external 16-bit SRAM as two half-word accesses with
//             programmable wait states, stalls the pipeline while an access
//             is in flight, and holds the MEM/WB pipeline register.
//  Ports    : clk, rst (async, active low)
//             execute side : wb_en_i, mem_r_en_i, mem_w_en_i, alu_res_i,
//                            val_rm_i, dest_i, stall_o
//             MEM/WB side  : wb_en_o, mem_r_en_o, alu_res_o, mem_data_o, dest_o
//             SRAM side    : sram_addr_o, sram_dq_o, sram_dq_oe_o, sram_dq_i,
//                            sram_we_n_o
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_i,
  input  logic               mem_r_en_i,
  input  logic               mem_w_en_i,
  input  logic [31:0]        alu_res_i,
  input  logic [31:0]        val_rm_i,
  input  logic [3:0]         dest_i,
  output logic               stall_o,
  output logic               wb_en_o,
  output logic               mem_r_en_o,
  output logic [31:0]        alu_res_o,
  output logic [31:0]        mem_data_o,
  output logic [3:0]         dest_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n_o
);

  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [SRAM_AW-2:0] word_addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               is_read;
  logic               req;
  logic               last_beat;
  logic [SRAM_AW:0]   off;
  logic               unused_off_bits;

  // Only the low SRAM_AW+1 bits of the offset are needed; subtraction modulo
  // 2^32 agrees with this narrower subtraction on those bits.
  assign off             = alu_res_i[SRAM_AW:0] - BASE[SRAM_AW:0];
  assign unused_off_bits = ^off[1:0];

  assign req       = mem_r_en_i | mem_w_en_i;
  assign last_beat = (cnt == WAIT_LAST);

  // Forced low while reset is asserted so the pipeline is released at once,
  // even if execute is still presenting a memory request.
  assign stall_o = rst & (((state == IDLE) & req) | (state == LO) | (state == HI));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = LO;
          cnt_nx   = 4'd0;
        end
      end
      LO: begin
        if (last_beat) begin
          state_nx = HI;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HI: begin
        if (last_beat) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      word_addr <= '0;
      wdata     <= 32'd0;
      rdata     <= 32'd0;
      is_read   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // Request is captured once; execute outputs are ignored until DONE.
      if ((state == IDLE) && req) begin
        word_addr <= off[SRAM_AW:2];
        wdata     <= val_rm_i;
        is_read   <= mem_r_en_i;
      end
      // Read data is sampled on the final wait cycle of each half.
      if (is_read && last_beat) begin
        if (state == LO) rdata[15:0]  <= sram_dq_i;
        if (state == HI) rdata[31:16] <= sram_dq_i;
      end
    end
  end

  always_comb begin
    sram_addr_o  = '0;
    sram_dq_o    = 16'd0;
    sram_dq_oe_o = 1'b0;
    sram_we_n_o  = 1'b1;
    case (state)
      LO: begin
        sram_addr_o = {word_addr, 1'b0};
        if (!is_read) begin
          sram_dq_o    = wdata[15:0];
          sram_dq_oe_o = 1'b1;
          sram_we_n_o  = 1'b0;
        end
      end
      HI: begin
        sram_addr_o = {word_addr, 1'b1};
        if (!is_read) begin
          sram_dq_o    = wdata[31:16];
          sram_dq_oe_o = 1'b1;
          sram_we_n_o  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // MEM/WB register: bubble while stalled, otherwise follow execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_o    <= 1'b0;
      mem_r_en_o <= 1'b0;
      alu_res_o  <= 32'd0;
      mem_data_o <= 32'd0;
      dest_o     <= 4'd0;
    end else if (stall_o) begin
      wb_en_o    <= 1'b0;
      mem_r_en_o <= 1'b0;
    end else begin
      wb_en_o    <= wb_en_i;
      mem_r_en_o <= mem_r_en_i;
      alu_res_o  <= alu_res_i;
      dest_o     <= dest_i;
      if ((state == DONE) && is_read) mem_data_o <= rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_sram_ctrl
//  Purpose  : Directed self-checking bench for mem_stage_sram_ctrl. Three
//             instances (WAIT_CYCLES = 1, 0, 3) share the execute-side inputs;
//             a small SRAM model answers each instance and accepts writes from
//             the WAIT_CYCLES = 1 instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_i, mem_r_en_i, mem_w_en_i;
  logic [31:0] alu_res_i, val_rm_i;
  logic [3:0]  dest_i;

  // per-instance outputs: index 0 -> WAIT 1, 1 -> WAIT 0, 2 -> WAIT 3
  logic        stall   [3];
  logic        wb_en   [3];
  logic        mr_en   [3];
  logic [31:0] alu_res [3];
  logic [31:0] mdata   [3];
  logic [3:0]  dest    [3];
  logic [17:0] saddr   [3];
  logic [15:0] sdq_o   [3];
  logic        soe     [3];
  logic [15:0] sdq_i   [3];
  logic        swe_n   [3];

  logic [15:0] mem [16];
  logic        loaded = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;

  logic        cur_stall, cur_we_n, cur_wb;
  logic [17:0] cur_addr;
  logic [15:0] cur_dq;

  logic [17:0] rec_addr [40];
  logic [15:0] rec_dq   [40];
  logic        rec_we   [40];

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .wb_en_i(wb_en_i), .mem_r_en_i(mem_r_en_i), .mem_w_en_i(mem_w_en_i),
    .alu_res_i(alu_res_i), .val_rm_i(val_rm_i), .dest_i(dest_i), .stall_o(stall[0]),
    .wb_en_o(wb_en[0]), .mem_r_en_o(mr_en[0]), .alu_res_o(alu_res[0]), .mem_data_o(mdata[0]),
    .dest_o(dest[0]), .sram_addr_o(saddr[0]), .sram_dq_o(sdq_o[0]), .sram_dq_oe_o(soe[0]),
    .sram_dq_i(sdq_i[0]), .sram_we_n_o(swe_n[0]));

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .wb_en_i(wb_en_i), .mem_r_en_i(mem_r_en_i), .mem_w_en_i(mem_w_en_i),
    .alu_res_i(alu_res_i), .val_rm_i(val_rm_i), .dest_i(dest_i), .stall_o(stall[1]),
    .wb_en_o(wb_en[1]), .mem_r_en_o(mr_en[1]), .alu_res_o(alu_res[1]), .mem_data_o(mdata[1]),
    .dest_o(dest[1]), .sram_addr_o(saddr[1]), .sram_dq_o(sdq_o[1]), .sram_dq_oe_o(soe[1]),
    .sram_dq_i(sdq_i[1]), .sram_we_n_o(swe_n[1]));

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .wb_en_i(wb_en_i), .mem_r_en_i(mem_r_en_i), .mem_w_en_i(mem_w_en_i),
    .alu_res_i(alu_res_i), .val_rm_i(val_rm_i), .dest_i(dest_i), .stall_o(stall[2]),
    .wb_en_o(wb_en[2]), .mem_r_en_o(mr_en[2]), .alu_res_o(alu_res[2]), .mem_data_o(mdata[2]),
    .dest_o(dest[2]), .sram_addr_o(saddr[2]), .sram_dq_o(sdq_o[2]), .sram_dq_oe_o(soe[2]),
    .sram_dq_i(sdq_i[2]), .sram_we_n_o(swe_n[2]));

  // SRAM model: asynchronous read, write on rising edge while we_n is low.
  assign sdq_i[0] = mem[saddr[0][3:0]];
  assign sdq_i[1] = mem[saddr[1][3:0]];
  assign sdq_i[2] = mem[saddr[2][3:0]];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
      mem[6] <= 16'h5678;
      mem[7] <= 16'h1234;
      loaded <= 1'b1;
    end else if (!swe_n[0]) begin
      mem[saddr[0][3:0]] <= sdq_o[0];
    end
  end

  always_comb begin
    cur_stall = stall[0];
    cur_we_n  = swe_n[0];
    cur_wb    = wb_en[0];
    cur_addr  = saddr[0];
    cur_dq    = sdq_o[0];
    if (sel == 1 || sel == 2) begin
      cur_stall = stall[sel];
      cur_we_n  = swe_n[sel];
      cur_wb    = wb_en[sel];
      cur_addr  = saddr[sel];
      cur_dq    = sdq_o[sel];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step through the stalled cycles of the selected instance, recording the
  // SRAM bus each cycle. Returns on the first unstalled cycle (bounded).
  task automatic run_access(output int n, output int wb_hi, output int we_low);
    n = 0; wb_hi = 0; we_low = 0;
    #1;
    while (cur_stall && n < 40) begin
      rec_addr[n] = cur_addr;
      rec_dq[n]   = cur_dq;
      rec_we[n]   = cur_we_n;
      if (n >= 1 && cur_wb) wb_hi++;
      if (!cur_we_n) we_low++;
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic set_in(input logic wb, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
    wb_en_i = wb; mem_r_en_i = r; mem_w_en_i = w;
    alu_res_i = a; val_rm_i = v; dest_i = d;
  endtask

  initial begin
    int n, wbh, wel;
    rst = 1'b0;
    set_in(0, 0, 0, 32'd0, 32'd0, 4'd0);

    // reset values
    #2;
    chk("rst_stall", {31'd0, stall[0]}, 32'd0);
    chk("rst_we_n",  {31'd0, swe_n[0]}, 32'd1);
    chk("rst_oe",    {31'd0, soe[0]},   32'd0);
    chk("rst_addr",  {14'd0, saddr[0]}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en[0]}, 32'd0);
    chk("rst_alu",   alu_res[0],        32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // ALU op: one cycle, no stall
    @(negedge clk);
    set_in(1, 0, 0, 32'h1234, 32'd0, 4'd3);
    #1 chk("alu_stall", {31'd0, stall[0]}, 32'd0);
    @(negedge clk);
    chk("alu_res",    alu_res[0],         32'h1234);
    chk("alu_dest",   {28'd0, dest[0]},   32'd3);
    chk("alu_wb_en",  {31'd0, wb_en[0]},  32'd1);
    chk("alu_stall2", {31'd0, stall[0]},  32'd0);

    // store 0xDEADBEEF at 1032
    set_in(0, 0, 1, 32'd1032, 32'hDEADBEEF, 4'd1);
    run_access(n, wbh, wel);
    chk("st_stall_len", n,   32'd5);
    chk("st_wb_bubble", wbh, 32'd0);
    chk("st_c0_we_n",   {31'd0, rec_we[0]}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("st_c%0d_addr", i), {14'd0, rec_addr[i]}, (i <= 2) ? 32'd4 : 32'd5);
      chk($sformatf("st_c%0d_dq", i),   {16'd0, rec_dq[i]},   (i <= 2) ? 32'hBEEF : 32'hDEAD);
      chk($sformatf("st_c%0d_we_n", i), {31'd0, rec_we[i]},   32'd0);
    end
    @(negedge clk);
    chk("st_mem4",  {16'd0, mem[4]},    32'hBEEF);
    chk("st_mem5",  {16'd0, mem[5]},    32'hDEAD);
    chk("st_wb_en", {31'd0, wb_en[0]},  32'd0);

    // load from 1032
    set_in(1, 1, 0, 32'd1032, 32'd0, 4'd5);
    run_access(n, wbh, wel);
    chk("ld_stall_len", n,   32'd5);
    chk("ld_wb_bubble", wbh, 32'd0);
    chk("ld_we_low",    wel, 32'd0);
    @(negedge clk);
    chk("ld_data",   mdata[0],          32'hDEADBEEF);
    chk("ld_mr_en",  {31'd0, mr_en[0]}, 32'd1);
    chk("ld_wb_en",  {31'd0, wb_en[0]}, 32'd1);
    chk("ld_dest",   {28'd0, dest[0]},  32'd5);
    chk("ld_alu",    alu_res[0],        32'd1032);

    // back-to-back: load from 1036, then store at 1040 straight after DONE
    set_in(1, 1, 0, 32'd1036, 32'd0, 4'd7);
    run_access(n, wbh, wel);
    chk("b2b_ld_len", n, 32'd5);
    @(negedge clk);
    chk("b2b_ld_data",  mdata[0],          32'h12345678);
    chk("b2b_ld_wb_en", {31'd0, wb_en[0]}, 32'd1);
    chk("b2b_ld_dest",  {28'd0, dest[0]},  32'd7);
    set_in(0, 0, 1, 32'd1040, 32'hCAFEF00D, 4'd9);
    #1 chk("b2b_restall", {31'd0, stall[0]}, 32'd1);
    run_access(n, wbh, wel);
    chk("b2b_st_len",    n,   32'd5);
    chk("b2b_st_wb_dup", wbh, 32'd0);
    @(negedge clk);
    chk("b2b_mem8",  {16'd0, mem[8]},   32'hF00D);
    chk("b2b_mem9",  {16'd0, mem[9]},   32'hCAFE);
    chk("b2b_wb_en", {31'd0, wb_en[0]}, 32'd0);

    // reset asserted during the HI half of a store
    set_in(0, 0, 1, 32'd1040, 32'h11112222, 4'd2);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    chk("mid_hi_addr", {14'd0, saddr[0]}, 32'd9);
    chk("mid_hi_dq",   {16'd0, sdq_o[0]}, 32'h1111);
    rst = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall[0]}, 32'd0);
    chk("arst_we_n",  {31'd0, swe_n[0]}, 32'd1);
    chk("arst_oe",    {31'd0, soe[0]},   32'd0);
    chk("arst_addr",  {14'd0, saddr[0]}, 32'd0);
    chk("arst_dq",    {16'd0, sdq_o[0]}, 32'd0);
    chk("arst_data",  mdata[0],          32'd0);
    chk("arst_alu",   alu_res[0],        32'd0);
    chk("arst_dest",  {28'd0, dest[0]},  32'd0);
    set_in(0, 0, 0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_stall", {31'd0, stall[0]}, 32'd0);
    chk("rel_we_n",  {31'd0, swe_n[0]}, 32'd1);
    chk("rel_mem8",  {16'd0, mem[8]},   32'h2222);
    chk("rel_mem9",  {16'd0, mem[9]},   32'hCAFE);

    // WAIT_CYCLES = 0, both enables set: read only
    @(negedge clk);
    sel = 1;
    set_in(1, 1, 1, 32'd1032, 32'hFFFFFFFF, 4'd2);
    run_access(n, wbh, wel);
    chk("w0_stall_len", n,   32'd3);
    chk("w0_we_low",    wel, 32'd0);
    @(negedge clk);
    chk("w0_data",  mdata[1],          32'hDEADBEEF);
    chk("w0_mr_en", {31'd0, mr_en[1]}, 32'd1);
    chk("w0_mem4",  {16'd0, mem[4]},   32'hBEEF);
    set_in(0, 0, 0, 32'd0, 32'd0, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // WAIT_CYCLES = 3
    @(negedge clk);
    sel = 2;
    set_in(1, 1, 0, 32'd1036, 32'd0, 4'd4);
    run_access(n, wbh, wel);
    chk("w3_stall_len", n,   32'd9);
    chk("w3_wb_bubble", wbh, 32'd0);
    @(negedge clk);
    chk("w3_data",  mdata[2],          32'h12345678);
    chk("w3_wb_en", {31'd0, wb_en[2]}, 32'd1);
    set_in(0, 0, 0, 32'd0, 32'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
